// File: rtl/core_irq_controller.sv
// 64-entry interrupt controller: config table, pending latch, priority select, VALID/ACK delivery.
// Optional build macro: MIST1032ISA_IRQ_LEVEL_TRIGGER_EN selects level-sensitive lines instead of rising edges.
module core_irq_controller #(
    parameter logic P_RESET_MASK = 1'b1
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iIRQ_CONFIG_TABLE_REQ,
    input  logic [5:0]  iIRQ_CONFIG_TABLE_ENTRY,
    input  logic        iIRQ_CONFIG_TABLE_FLAG_MASK,
    input  logic        iIRQ_CONFIG_TABLE_FLAG_VALID,
    input  logic [1:0]  iIRQ_CONFIG_TABLE_FLAG_LEVEL,
    input  logic [63:0] iIRQ_LINE,
    output logic        oINTERRUPT_VALID,
    input  logic        iINTERRUPT_ACK,
    output logic [5:0]  oINTERRUPT_NUM
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELIVER,
        ST_DEAD
    } state_t;

    logic [63:0]       valid_q, valid_d;
    logic [63:0]       mask_q, mask_d;
    logic [63:0][1:0]  level_q, level_d;
    logic [63:0]       pending_q, pending_d;
    logic [63:0]       set_vec;
    logic [63:0]       eligible;
    logic              sel_any_q, sel_any_d;
    logic [5:0]        sel_num_q, sel_num_d;
    logic [1:0]        sel_lvl;
    logic              ack_fire;

    state_t            state_q;
    logic              irq_valid_q;
    logic [5:0]        irq_num_q;

`ifdef MIST1032ISA_IRQ_LEVEL_TRIGGER_EN
    // A line held high keeps re-setting pending, which also defeats the ack clear.
    assign set_vec = iIRQ_LINE & valid_q;
`else
    logic [63:0] line_q, line_d;

    always_comb begin
        line_d = iIRQ_LINE;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign set_vec = iIRQ_LINE & ~line_q & valid_q;
`endif

    assign ack_fire = (state_q == ST_DELIVER) && iINTERRUPT_ACK;
    assign eligible = pending_q & valid_q & ~mask_q;

    always_comb begin
        valid_d   = valid_q;
        mask_d    = mask_q;
        level_d   = level_q;
        pending_d = pending_q;
        if (ack_fire) begin
            pending_d[irq_num_q] = 1'b0;
        end
        // A set in the ack cycle wins over the ack clear.
        pending_d = pending_d | set_vec;
        if (iIRQ_CONFIG_TABLE_REQ) begin
            valid_d[iIRQ_CONFIG_TABLE_ENTRY] = iIRQ_CONFIG_TABLE_FLAG_VALID;
            mask_d[iIRQ_CONFIG_TABLE_ENTRY]  = iIRQ_CONFIG_TABLE_FLAG_MASK;
            level_d[iIRQ_CONFIG_TABLE_ENTRY] = iIRQ_CONFIG_TABLE_FLAG_LEVEL;
            if (!iIRQ_CONFIG_TABLE_FLAG_VALID) begin
                pending_d[iIRQ_CONFIG_TABLE_ENTRY] = 1'b0;
            end
        end
    end

    // Strict '>' keeps the lowest index among equal levels.
    always_comb begin
        sel_any_d = 1'b0;
        sel_num_d = '0;
        sel_lvl   = '0;
        for (int i = 0; i < 64; i++) begin
            if (eligible[i] && (!sel_any_d || (level_q[i] > sel_lvl))) begin
                sel_any_d = 1'b1;
                sel_num_d = 6'(i);
                sel_lvl   = level_q[i];
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            valid_q   <= '0;
            mask_q    <= {64{P_RESET_MASK}};
            level_q   <= '0;
            pending_q <= '0;
            sel_any_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            level_q   <= level_d;
            pending_q <= pending_d;
            sel_any_q <= sel_any_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        sel_num_q <= sel_num_d;
    end

    // The registered selection can be one cycle old; re-check eligibility before offering it.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q     <= ST_IDLE;
            irq_valid_q <= 1'b0;
            irq_num_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_any_q && eligible[sel_num_q]) begin
                        irq_valid_q <= 1'b1;
                        irq_num_q   <= sel_num_q;
                        state_q     <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (iINTERRUPT_ACK) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    irq_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign oINTERRUPT_VALID = irq_valid_q;
    assign oINTERRUPT_NUM   = irq_num_q;

endmodule

// File: tb/tb_core_irq_controller.sv
// Directed vector bench for core_irq_controller (edge-triggered build).
module tb_core_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [5:0]  ent;
    logic        fmask;
    logic        fvalid;
    logic [1:0]  flevel;
    logic [63:0] line;
    logic        ovalid;
    logic        ack;
    logic [5:0]  onum;

    int n_tests = 0;
    int n_fail  = 0;

    core_irq_controller #(.P_RESET_MASK(1'b1)) dut (
        .iCLOCK                       (clk),
        .iRESET_SYNC                  (rst),
        .iIRQ_CONFIG_TABLE_REQ        (req),
        .iIRQ_CONFIG_TABLE_ENTRY      (ent),
        .iIRQ_CONFIG_TABLE_FLAG_MASK  (fmask),
        .iIRQ_CONFIG_TABLE_FLAG_VALID (fvalid),
        .iIRQ_CONFIG_TABLE_FLAG_LEVEL (flevel),
        .iIRQ_LINE                    (line),
        .oINTERRUPT_VALID             (ovalid),
        .iINTERRUPT_ACK               (ack),
        .oINTERRUPT_NUM               (onum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [5:0]  ent;
        logic        vld;
        logic        msk;
        logic [1:0]  lvl;
        logic [63:0] line;
        logic        ack;
        logic        ev;
        logic [5:0]  en;
        logic        cn;
    } vec_t;

    vec_t tbl[$];
    int   vec_id = 0;

    function automatic logic [63:0] b(input int i);
        logic [63:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    task automatic add(input logic r, input logic rq, input logic [5:0] e, input logic v,
                       input logic m, input logic [1:0] l, input logic [63:0] ln_v,
                       input logic a, input logic ev, input logic [5:0] en, input logic cn);
        vec_t t;
        t.rst = r; t.req = rq; t.ent = e; t.vld = v; t.msk = m; t.lvl = l;
        t.line = ln_v; t.ack = a; t.ev = ev; t.en = en; t.cn = cn;
        tbl.push_back(t);
    endtask

    task automatic wr(input logic [5:0] e, input logic v, input logic m, input logic [1:0] l);
        add(1'b0, 1'b1, e, v, m, l, 64'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic ln(input logic [63:0] lv, input logic a, input logic ev, input logic [5:0] en);
        add(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, lv, a, ev, en, ev);
    endtask

    task automatic check(input string nm, input logic ev, input logic [5:0] en, input logic cn);
        n_tests++;
        if (ovalid !== ev) begin
            n_fail++;
            $display("FAIL %s valid: got %0b expected %0b", nm, ovalid, ev);
        end
        if (cn) begin
            n_tests++;
            if (onum !== en) begin
                n_fail++;
                $display("FAIL %s num: got %0d expected %0d", nm, onum, en);
            end
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic [5:0] e, input logic v,
                         input logic m, input logic [1:0] l, input logic [63:0] lv, input logic a);
        @(negedge clk);
        rst = r; req = rq; ent = e; fvalid = v; fmask = m; flevel = l; line = lv; ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].req, tbl[k].ent, tbl[k].vld, tbl[k].msk, tbl[k].lvl,
                  tbl[k].line, tbl[k].ack);
            check($sformatf("vec%0d", vec_id), tbl[k].ev, tbl[k].en, tbl[k].cn);
            vec_id++;
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; ent = '0; fvalid = 1'b0; fmask = 1'b0; flevel = '0;
        line = '0; ack = 1'b0;

        // Reset, single edge on entry 5, ack, no re-offer
        add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 6'd0, 1'b1);
        wr(6'd5, 1'b1, 1'b0, 2'd2);
        ln(b(5), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd5);
        ln(64'd0, 1'b0, 1'b1, 6'd5);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Level 3 beats level 1; ack while idle is ignored
        wr(6'd3, 1'b1, 1'b0, 2'd1);
        wr(6'd40, 1'b1, 1'b0, 2'd3);
        ln(b(3) | b(40), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd40);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd3);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Equal levels: lower index first
        wr(6'd7, 1'b1, 1'b0, 2'd2);
        wr(6'd9, 1'b1, 1'b0, 2'd2);
        ln(b(7) | b(9), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd7);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd9);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Ack and a new rise on the same entry: it is offered again
        ln(b(7), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd7);
        ln(b(7), 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd7);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Rise on an invalid entry is discarded
        ln(b(20), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        wr(6'd20, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 4; i++) ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Masked entry latches but is not offered
        wr(6'd12, 1'b1, 1'b1, 2'd0);
        ln(b(12), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        run_table();

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0);
            check($sformatf("masked_wait%0d", i), 1'b0, 6'd0, 1'b0);
        end

        wr(6'd12, 1'b1, 1'b0, 2'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd12);
        ln(64'd0, 1'b1, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);

        // Offer entry 5 again for the hold / reset sequence
        ln(b(5), 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b0, 6'd0);
        ln(64'd0, 1'b0, 1'b1, 6'd5);
        run_table();

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0);
            check($sformatf("hold%0d", i), 1'b1, 6'd5, 1'b1);
        end

        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0);
        check("reset_drop", 1'b0, 6'd0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, (i == 1) ? b(5) : 64'd0, 1'b0);
            check($sformatf("post_reset%0d", i), 1'b0, 6'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_irq_controller.md
Name: core_irq_controller

Overview:
Interrupt controller feeding the core's interrupt input (iINTERRUPT_VALID / oINTERRUPT_ACK / iINTERRUPT_NUM) and consuming the core's IRQ config-table write stream (oIO_IRQ_CONFIG_TABLE_*).
- Holds a 64-entry config table with valid, mask and 2-bit priority level per entry.
- Latches rising edges of 64 interrupt lines into pending bits.
- Selects the highest-priority eligible pending IRQ and delivers it to the core with a VALID/ACK handshake.

Parameters:
P_RESET_MASK, 1'b1, mask bit loaded into every table entry at reset (1 = masked).

Ports:
iCLOCK  input  1  core clock; all logic on rising edge
iRESET_SYNC  input  1  synchronous reset, active-high
iIRQ_CONFIG_TABLE_REQ  input  1  config write strobe; one write per cycle it is high
iIRQ_CONFIG_TABLE_ENTRY  input  6  entry index written
iIRQ_CONFIG_TABLE_FLAG_MASK  input  1  new mask bit (1 = masked)
iIRQ_CONFIG_TABLE_FLAG_VALID  input  1  new valid bit
iIRQ_CONFIG_TABLE_FLAG_LEVEL  input  2  new priority level (3 highest)
iIRQ_LINE  input  64  interrupt lines, already synchronous to iCLOCK
oINTERRUPT_VALID  output  1  interrupt offered to core
iINTERRUPT_ACK  input  1  core accepts offered interrupt
oINTERRUPT_NUM  output  6  number of the offered interrupt

Behaviour:
- Reset (iRESET_SYNC high at a clock edge):
  - all entries: valid=0, mask=P_RESET_MASK, level=0
  - pending=0; line history register=0
  - FSM to IDLE; oINTERRUPT_VALID=0; oINTERRUPT_NUM=0
  - reset mid-delivery drops the offer with no ack required
- Config write: when REQ=1 the entry is updated at that edge; the new value takes effect from the next cycle. An edge on the same entry in the same cycle is judged against the old entry.
- Writing valid=0 clears that entry's pending bit at the same edge.
- Edge detect:
  - rise[i] = iIRQ_LINE[i] & ~line_q[i]; line_q <= iIRQ_LINE every cycle
  - pending[i] set at the edge when rise[i] and entry valid
  - rises on invalid entries are discarded
  - mask does not block latching
- Eligible[i] = pending[i] & valid[i] & ~mask[i].
- Selection: highest level wins; ties go to the lowest entry number. Combinational over the 64 entries and registered into the output.
- FSM:
  - IDLE: if any entry is eligible, load oINTERRUPT_NUM=selected, set oINTERRUPT_VALID=1, go to DELIVER.
  - DELIVER: oINTERRUPT_VALID and oINTERRUPT_NUM stay stable until iINTERRUPT_ACK=1 is sampled. On ack: clear pending[NUM], drop VALID, go to IDLE. The next offer can appear at the earliest on the second edge after ack (one dead cycle).
- Ack and a new rise on the same entry in the same cycle: the set wins and the entry stays pending.
- Mask or invalidate of the offered entry during DELIVER does not retract VALID; the core must still ack. Invalidation clears pending, so the ack clear is a no-op.
- iINTERRUPT_ACK while VALID=0 is ignored.
- Latency: line first sampled high at edge t -> pending at t+1 -> oINTERRUPT_VALID=1 after edge t+2 (FSM idle, entry valid and unmasked).
- A higher-priority IRQ arriving during DELIVER does not preempt; it is offered after the current ack.
- Unmasking a pending entry makes it eligible from the cycle after the write.

Optional Feature:
MIST1032ISA_IRQ_LEVEL_TRIGGER_EN
- Defined: lines are level-sensitive.
  - pending[i] is set every cycle iIRQ_LINE[i]=1 and the entry is valid
  - ack clears pending only if the line is low in the ack cycle; otherwise the IRQ is re-offered after the dead cycle
  - line_q and the rise logic are not built
- Undefined: edge-triggered behaviour as above.

Test Plan:
- Reset, write entry 5 valid=1 mask=0 level=2, pulse iIRQ_LINE[5] for 1 cycle at edge t -> VALID=1 with NUM=5 after edge t+2; ack -> VALID=0 next edge; no re-offer.
- Entries 3 (level 1) and 40 (level 3) rise together -> NUM=40 first; after ack and one dead cycle NUM=3.
- Entries 7 and 9 both level 2 rise together -> NUM=7, then NUM=9.
- Entry 12 masked, line rises -> no VALID for 20 cycles; unmask write -> VALID with NUM=12 two edges after the write.
- Rise on invalid entry 20, then validate and unmask -> no VALID ever.
- During DELIVER of NUM=5: hold ACK low 10 cycles -> VALID and NUM stay stable. Assert iRESET_SYNC -> VALID=0 next edge; no re-offer after reset.
